// File: rtl/disp_pack_rgb888_pkg.sv
// Shared encodings for the RGB888 display packer: FIFO entry layout,
// byte-phase values and packer FSM states.
package disp_pack_rgb888_pkg;

    localparam int WORD_W  = 32;
    localparam int SOF_BIT = 32;
    localparam int EOL_BIT = 33;
    localparam int ENTRY_W = 34;

    // Phase = number of residual bytes held in the accumulator.
    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

endpackage

// File: rtl/disp_pack_rgb888_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; the head entry is presented on
// rd_data whenever empty is low, and a read in a full cycle frees room for a write.
module fifo_fwft #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [AW:0]      count_r;
    logic             wr_ok_s, rd_ok_s;

    assign empty   = (count_r == CNT_ZERO);
    assign full    = (count_r == CNT_FULL);
    assign rd_ok_s = rd_en && !empty;
    assign wr_ok_s = wr_en && (!full || rd_ok_s);

    // Head presentation; an empty FIFO shows zeros.
    always_comb begin
        rd_data = {WIDTH{1'b0}};
        if (empty) begin
            rd_data = {WIDTH{1'b0}};
        end else begin
            rd_data = mem_r[rd_ptr_r];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/disp_pack_rgb888.sv
// Packs active RGB888 display pixels into 32-bit little-endian words (4 pixels
// -> 3 words) and queues them with frame/line sideband behind a valid/ready port.
module disp_pack_rgb888
    import disp_pack_rgb888_pkg::*;
#(
    parameter int BPC_BOARD  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DROPW      = 16
) (
    input  logic                 clk_pix,
    input  logic                 rst_pix_n,
    input  logic                 disp_de,
    input  logic                 disp_frame,
    input  logic [BPC_BOARD-1:0] disp_r,
    input  logic [BPC_BOARD-1:0] disp_g,
    input  logic [BPC_BOARD-1:0] disp_b,
    output logic [31:0]          out_data,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 stat_clr,
    output logic                 overflow,
    output logic                 fmt_err,
    output logic [DROPW-1:0]     drop_cnt
);
    localparam logic [DROPW-1:0] DROP_ONE  = {{(DROPW-1){1'b0}}, 1'b1};
    localparam logic [DROPW-1:0] DROP_ZERO = {DROPW{1'b0}};

    logic                 de_q_r, frame_q_r;
    logic [BPC_BOARD-1:0] r_q_r, g_q_r, b_q_r;
    state_e               state_r, state_nxt_s;
    phase_e               phase_r, phase_nxt_s;
    logic [23:0]          acc_r, acc_nxt_s;
    logic                 sof_pend_r;
    logic                 pack_s, last_s, emit_s, eol_s, fmt_s;
    logic [WORD_W-1:0]    word_s;
    logic                 emit_r;
    logic [ENTRY_W-1:0]   entry_r, head_s;
    logic                 full_s, empty_s, drop_s;
    logic                 overflow_r, fmt_err_r;
    logic [DROPW-1:0]     drop_cnt_r;

    function automatic logic [DROPW-1:0] sat_inc(input logic [DROPW-1:0] v);
        if (&v) return v;
        else    return v + DROP_ONE;
    endfunction

    // The q pixel is the last of its line when the live enable has already dropped.
    assign last_s = de_q_r && !disp_de;

    // Input q-stage.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            de_q_r    <= 1'b0;
            frame_q_r <= 1'b0;
            r_q_r     <= {BPC_BOARD{1'b0}};
            g_q_r     <= {BPC_BOARD{1'b0}};
            b_q_r     <= {BPC_BOARD{1'b0}};
        end else begin
            de_q_r    <= disp_de;
            frame_q_r <= disp_frame;
            r_q_r     <= disp_r;
            g_q_r     <= disp_g;
            b_q_r     <= disp_b;
        end
    end

    // Frame FSM next state and byte packer.
    always_comb begin
        state_nxt_s = state_r;
        phase_nxt_s = phase_r;
        acc_nxt_s   = acc_r;
        pack_s      = 1'b0;
        emit_s      = 1'b0;
        eol_s       = 1'b0;
        fmt_s       = 1'b0;
        word_s      = 32'h0000_0000;
        case (state_r)
            ST_SYNC: begin
                if (frame_q_r) state_nxt_s = ST_ARMED;
                else           state_nxt_s = ST_SYNC;
            end
            ST_ARMED: begin
                if (frame_q_r) begin
                    state_nxt_s = ST_ARMED;
                end else if (de_q_r) begin
                    state_nxt_s = ST_ACTIVE;
                    pack_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_ACTIVE: begin
                if (frame_q_r) begin
                    state_nxt_s = ST_ARMED;
                    phase_nxt_s = PH_0;
                    acc_nxt_s   = 24'h00_0000;
                    fmt_s       = (phase_r != PH_0);
                end else begin
                    state_nxt_s = ST_ACTIVE;
                    pack_s      = de_q_r;
                end
            end
            default: state_nxt_s = ST_SYNC;
        endcase

        if (pack_s) begin
            case (phase_r)
                PH_0: begin
                    acc_nxt_s   = {b_q_r, g_q_r, r_q_r};
                    phase_nxt_s = PH_3;
                end
                PH_3: begin
                    word_s      = {r_q_r, acc_r};
                    acc_nxt_s   = {8'h00, b_q_r, g_q_r};
                    phase_nxt_s = PH_2;
                    emit_s      = 1'b1;
                end
                PH_2: begin
                    word_s      = {g_q_r, r_q_r, acc_r[15:0]};
                    acc_nxt_s   = {16'h0000, b_q_r};
                    phase_nxt_s = PH_1;
                    emit_s      = 1'b1;
                end
                PH_1: begin
                    word_s      = {b_q_r, g_q_r, r_q_r, acc_r[7:0]};
                    acc_nxt_s   = 24'h00_0000;
                    phase_nxt_s = PH_0;
                    emit_s      = 1'b1;
                end
                default: begin
                    acc_nxt_s   = 24'h00_0000;
                    phase_nxt_s = PH_0;
                end
            endcase
            // A line that ends mid-group loses its residual bytes.
            if (last_s && (phase_nxt_s != PH_0)) begin
                fmt_s       = 1'b1;
                phase_nxt_s = PH_0;
                acc_nxt_s   = 24'h00_0000;
            end else begin
                eol_s = last_s;
            end
        end else begin
            eol_s = 1'b0;
        end
    end

    // Packer state, sof arming and the emitted-word register.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_r    <= ST_SYNC;
            phase_r    <= PH_0;
            acc_r      <= 24'h00_0000;
            sof_pend_r <= 1'b0;
            emit_r     <= 1'b0;
            entry_r    <= {ENTRY_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            phase_r <= phase_nxt_s;
            acc_r   <= acc_nxt_s;
            if (frame_q_r)   sof_pend_r <= 1'b1;
            else if (emit_s) sof_pend_r <= 1'b0;
            emit_r <= emit_s;
            if (emit_s) entry_r <= {eol_s, sof_pend_r, word_s};
        end
    end

    fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_pix),
        .rst_n   (rst_pix_n),
        .wr_en   (emit_r),
        .wr_data (entry_r),
        .rd_en   (out_ready),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign drop_s = emit_r && full_s && !out_ready;

    // Sticky status; a same-cycle event takes precedence over stat_clr.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            overflow_r <= 1'b0;
            fmt_err_r  <= 1'b0;
            drop_cnt_r <= DROP_ZERO;
        end else begin
            if (drop_s)        overflow_r <= 1'b1;
            else if (stat_clr) overflow_r <= 1'b0;
            if (fmt_s)         fmt_err_r  <= 1'b1;
            else if (stat_clr) fmt_err_r  <= 1'b0;
            if (drop_s)        drop_cnt_r <= stat_clr ? DROP_ONE : sat_inc(drop_cnt_r);
            else if (stat_clr) drop_cnt_r <= DROP_ZERO;
        end
    end

    assign out_data  = head_s[WORD_W-1:0];
    assign out_sof   = head_s[SOF_BIT];
    assign out_eol   = head_s[EOL_BIT];
    assign out_valid = !empty_s;
    assign overflow  = overflow_r;
    assign fmt_err   = fmt_err_r;
    assign drop_cnt  = drop_cnt_r;

endmodule
